// File: rtl/multiport_reg_file_if.sv
// Bus bundle for multiport_reg_file: read ports, two write ports and the
// PC / SP / CCR control and status signals. clk and rst stay outside.
interface multiport_reg_file_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3,
  parameter int NUM_RD = 3,
  parameter int PC_W   = 32,
  parameter int SP_W   = 32,
  parameter int CCR_W  = 4
);
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     we0;
  logic                     we1;
  logic [AW-1:0]            wa0;
  logic [AW-1:0]            wa1;
  logic [DATA_W-1:0]        wd0;
  logic [DATA_W-1:0]        wd1;
  logic [1:0]               pc_op;
  logic [PC_W-1:0]          pc_wdata;
  logic [PC_W-1:0]          pc;
  logic [1:0]               sp_op;
  logic [SP_W-1:0]          sp_wdata;
  logic [SP_W-1:0]          sp;
  logic [CCR_W-1:0]         ccr_mask;
  logic [CCR_W-1:0]         ccr_wdata;
  logic [CCR_W-1:0]         ccr;

  modport master (
    output rd_addr, we0, we1, wa0, wa1, wd0, wd1,
           pc_op, pc_wdata, sp_op, sp_wdata, ccr_mask, ccr_wdata,
    input  rd_data, pc, sp, ccr
  );

  modport slave (
    input  rd_addr, we0, we1, wa0, wa1, wd0, wd1,
           pc_op, pc_wdata, sp_op, sp_wdata, ccr_mask, ccr_wdata,
    output rd_data, pc, sp, ccr
  );
endinterface

// File: rtl/multiport_reg_file.sv
// Decode-stage register file: NUM_RD combinational read ports with
// write-to-read bypass (port 1 beats port 0), two write ports, and the
// PC / SP / CCR special registers with their own update arithmetic.
module multiport_reg_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter int NUM_RD   = 3,
  parameter int PC_W     = 32,
  parameter int SP_W     = 32,
  parameter int SP_RESET = 2047,
  parameter int SP_STEP  = 2,
  parameter int CCR_W    = 4
) (
  input logic clk,
  input logic rst,
  multiport_reg_file_if.slave bus
);

  localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_int;
  logic [PC_W-1:0]          pc_q;
  logic [SP_W-1:0]          sp_q;
  logic [CCR_W-1:0]         ccr_q;

  // Addresses beyond the populated range read as zero and drop writes.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  // General register array; port 1 is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (bus.we0 && addr_ok(bus.wa0)) regs[bus.wa0] <= bus.wd0;
      if (bus.we1 && addr_ok(bus.wa1)) regs[bus.wa1] <= bus.wd1;
    end
  end

  // Read ports: stored value, overridden by wd0 then wd1 on address match.
  always_comb begin
    rd_data_int = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!rst && addr_ok(bus.rd_addr[k*AW +: AW])) begin
        rd_data_int[k*DATA_W +: DATA_W] = regs[bus.rd_addr[k*AW +: AW]];
        if (bus.we0 && bus.wa0 == bus.rd_addr[k*AW +: AW])
          rd_data_int[k*DATA_W +: DATA_W] = bus.wd0;
        if (bus.we1 && bus.wa1 == bus.rd_addr[k*AW +: AW])
          rd_data_int[k*DATA_W +: DATA_W] = bus.wd1;
      end
    end
  end

  // PC, SP and CCR update independently; all arithmetic wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      sp_q  <= SP_W'(SP_RESET);
      ccr_q <= '0;
    end else begin
      case (bus.pc_op)
        2'b01:   pc_q <= pc_q + PC_W'(1);
        2'b10:   pc_q <= bus.pc_wdata;
        2'b11:   pc_q <= bus.pc_wdata - PC_W'(1);
        default: pc_q <= pc_q;
      endcase
      case (bus.sp_op)
        2'b01:   sp_q <= sp_q - SP_W'(SP_STEP);
        2'b10:   sp_q <= sp_q + SP_W'(SP_STEP);
        2'b11:   sp_q <= bus.sp_wdata;
        default: sp_q <= sp_q;
      endcase
      ccr_q <= (ccr_q & ~bus.ccr_mask) | (bus.ccr_wdata & bus.ccr_mask);
    end
  end

  assign bus.rd_data = rd_data_int;
  assign bus.pc      = pc_q;
  assign bus.sp      = sp_q;
  assign bus.ccr     = ccr_q;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench for multiport_reg_file. Expected values go into a
// scoreboard queue as stimulus is driven and are popped at each check point.
module tb_multiport_reg_file;

  localparam int DATA_W = 16;
  localparam int AW     = 3;
  localparam int NUM_RD = 3;

  typedef struct {
    string       tag;
    int          sel;   // 0..2 read port, 3 pc, 4 sp, 5 ccr
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] model [8];

  multiport_reg_file_if #(.DATA_W(DATA_W), .AW(AW), .NUM_RD(NUM_RD),
                          .PC_W(32), .SP_W(32), .CCR_W(4)) bus ();

  multiport_reg_file #(.DATA_W(DATA_W), .NUM_REGS(8), .NUM_RD(NUM_RD),
                       .PC_W(32), .SP_W(32), .SP_RESET(2047), .SP_STEP(2),
                       .CCR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0, 1, 2: return 32'(bus.rd_data[sel*DATA_W +: DATA_W]);
      3:       return bus.pc;
      4:       return bus.sp;
      default: return 32'(bus.ccr);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0 = 0; bus.we1 = 0; bus.wa0 = '0; bus.wa1 = '0;
    bus.wd0 = '0; bus.wd1 = '0;
    bus.pc_op = 2'b00; bus.pc_wdata = '0;
    bus.sp_op = 2'b00; bus.sp_wdata = '0;
    bus.ccr_mask = '0; bus.ccr_wdata = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    bus.rd_addr = {a2, a1, a0};
  endtask

  initial begin
    idle();
    set_rd(0, 0, 0);
    // reset held: bypass suppressed and special ops ignored
    tick();
    bus.we0 = 1; bus.wa0 = 0; bus.wd0 = 16'hFFFF;
    bus.pc_op = 2'b01; bus.sp_op = 2'b01; bus.ccr_mask = 4'hF; bus.ccr_wdata = 4'hF;
    #1;
    expect_val("rst_bypass_rd0", 0, 32'h0);
    check_sb();
    tick();
    idle();
    rst = 0;
    #1;
    expect_val("rst_pc", 3, 32'h0);
    expect_val("rst_sp", 4, 32'd2047);
    expect_val("rst_ccr", 5, 32'h0);
    check_sb();
    for (int i = 0; i < 8; i++) begin
      set_rd(AW'(i), AW'(i), AW'(i));
      #1;
      for (int k = 0; k < NUM_RD; k++) expect_val($sformatf("rst_r%0d_p%0d", i, k), k, 32'h0);
      check_sb();
    end

    // bypass on port 2, then stored value
    set_rd(0, 0, 3);
    bus.we0 = 1; bus.wa0 = 3; bus.wd0 = 16'hBEEF;
    #1;
    expect_val("byp_p2", 2, 32'hBEEF);
    expect_val("byp_p0_other", 0, 32'h0);
    check_sb();
    tick();
    bus.we0 = 0;
    #1;
    expect_val("stored_p2", 2, 32'hBEEF);
    check_sb();

    // write collision: port 1 wins both bypass and storage
    set_rd(5, 5, 5);
    bus.we0 = 1; bus.wa0 = 5; bus.wd0 = 16'h1111;
    bus.we1 = 1; bus.wa1 = 5; bus.wd1 = 16'h2222;
    #1;
    expect_val("coll_byp", 0, 32'h2222);
    check_sb();
    tick();
    idle();
    #1;
    expect_val("coll_stored", 1, 32'h2222);
    check_sb();

    // distinct addresses: each port bypasses its own data
    set_rd(6, 7, 3);
    bus.we0 = 1; bus.wa0 = 6; bus.wd0 = 16'hA5A5;
    bus.we1 = 1; bus.wa1 = 7; bus.wd1 = 16'h5A5A;
    #1;
    expect_val("split_w0", 0, 32'hA5A5);
    expect_val("split_w1", 1, 32'h5A5A);
    expect_val("split_other", 2, 32'hBEEF);
    check_sb();
    tick();
    idle();

    // PC: load, wrap on increment, replay; no comb path from op to pc
    bus.pc_op = 2'b10; bus.pc_wdata = 32'hFFFF_FFFF;
    #1;
    expect_val("pc_no_comb", 3, 32'h0);
    check_sb();
    tick();
    expect_val("pc_load", 3, 32'hFFFF_FFFF);
    check_sb();
    bus.pc_op = 2'b01;
    tick();
    expect_val("pc_inc_wrap", 3, 32'h0);
    check_sb();
    bus.pc_op = 2'b11; bus.pc_wdata = 32'h40;
    tick();
    expect_val("pc_replay", 3, 32'h3F);
    check_sb();
    bus.pc_op = 2'b00;
    tick();
    expect_val("pc_hold", 3, 32'h3F);
    check_sb();

    // SP with CCR changing in the same cycles
    bus.sp_op = 2'b01;
    bus.ccr_mask = 4'b0101; bus.ccr_wdata = 4'b1111;
    tick();
    expect_val("ccr_mask0101", 5, 32'h5);
    bus.ccr_mask = 4'b1000; bus.ccr_wdata = 4'b0000;
    tick();
    expect_val("sp_push2", 4, 32'd2043);
    expect_val("ccr_hold_bits", 5, 32'h5);
    check_sb();
    bus.sp_op = 2'b10; bus.ccr_mask = 4'b1010; bus.ccr_wdata = 4'b1010;
    tick();
    expect_val("sp_pop", 4, 32'd2045);
    expect_val("ccr_set_rest", 5, 32'hF);
    check_sb();
    bus.sp_op = 2'b11; bus.sp_wdata = 32'd1; bus.ccr_mask = '0;
    tick();
    expect_val("sp_load", 4, 32'd1);
    check_sb();
    bus.sp_op = 2'b01;
    tick();
    expect_val("sp_push_wrap", 4, 32'hFFFF_FFFF);
    check_sb();
    idle();

    // reset mid-operation loses the write and all ops
    rst = 1;
    bus.we0 = 1; bus.wa0 = 2; bus.wd0 = 16'h1234;
    bus.pc_op = 2'b01; bus.sp_op = 2'b01; bus.ccr_mask = 4'hF; bus.ccr_wdata = 4'h0;
    tick();
    idle();
    rst = 0;
    set_rd(2, 3, 6);
    #1;
    expect_val("rst_mid_r2", 0, 32'h0);
    expect_val("rst_mid_r3", 1, 32'h0);
    expect_val("rst_mid_r6", 2, 32'h0);
    expect_val("rst_mid_ccr", 5, 32'h0);
    expect_val("rst_mid_pc", 3, 32'h0);
    expect_val("rst_mid_sp", 4, 32'd2047);
    check_sb();

    // random fill through both ports against a model array
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int n = 0; n < 12; n++) begin
      bus.we0 = 1'($urandom_range(0, 1)); bus.wa0 = AW'($urandom_range(0, 7));
      bus.wd0 = DATA_W'($urandom);
      bus.we1 = 1'($urandom_range(0, 1)); bus.wa1 = AW'($urandom_range(0, 7));
      bus.wd1 = DATA_W'($urandom);
      if (bus.we0) model[bus.wa0] = bus.wd0;
      if (bus.we1) model[bus.wa1] = bus.wd1;
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      set_rd(AW'(i), AW'(7 - i), AW'((i + 3) % 8));
      #1;
      expect_val($sformatf("rand_p0_r%0d", i), 0, 32'(model[i]));
      expect_val($sformatf("rand_p1_r%0d", 7 - i), 1, 32'(model[7 - i]));
      expect_val($sformatf("rand_p2_r%0d", (i + 3) % 8), 2, 32'(model[(i + 3) % 8]));
      check_sb();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiport_reg_file.md
# multiport_reg_file

Parametrised successor to the processor register file: a general-purpose register array with a configurable number of read ports and two write ports, plus dedicated PC, SP and CCR registers with on-block update arithmetic. It sits in the decode stage. Reads are combinational with write-to-read bypass, so a writeback and a dependent decode can share a cycle. All state updates occur on the rising clock edge.

## Interface
Parameters:
- DATA_W, 16, general-register and write-port width
- NUM_REGS, 8, number of general registers; AW = $clog2(NUM_REGS)
- NUM_RD, 3, number of read ports
- PC_W, 32, program-counter width
- SP_W, 32, stack-pointer width
- SP_RESET, 2047, SP value after reset
- SP_STEP, 2, SP adjustment per push/pop
- CCR_W, 4, condition-code width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- we0, we1  in  1  write enables, ports 0 and 1
- wa0, wa1  in  AW  write addresses
- wd0, wd1  in  DATA_W  write data
- pc_op  in  2  00 hold, 01 increment, 10 load, 11 load-minus-one (replay)
- pc_wdata  in  PC_W  PC load value
- pc  out  PC_W  current PC
- sp_op  in  2  00 hold, 01 push, 10 pop, 11 load
- sp_wdata  in  SP_W  SP load value
- sp  out  SP_W  current SP
- ccr_mask  in  CCR_W  per-flag write enable
- ccr_wdata  in  CCR_W  new flag values
- ccr  out  CCR_W  current CCR

## Operation
- Read port k returns reg[rd_addr_k], subject to bypass.
- Bypass: if we1 && wa1 == rd_addr_k, return wd1. Otherwise, if we0 && wa0 == rd_addr_k, return wd0. Otherwise return the stored value.
- An rd_addr_k >= NUM_REGS (non-power-of-two NUM_REGS) returns 0. A write to such an address is dropped.
- Write collision: if we0 && we1 && wa0 == wa1, port 1's data is stored and bypassed.
- PC update:
  - hold: unchanged
  - increment: pc+1, modulo 2^PC_W
  - load: pc_wdata
  - replay: pc_wdata-1, modulo 2^PC_W
- SP update:
  - push: sp-SP_STEP
  - pop: sp+SP_STEP
  - load: sp_wdata
  - all SP arithmetic is modulo 2^SP_W, with no saturation and no error flag
- CCR update: each bit i with ccr_mask[i]=1 takes ccr_wdata[i]; other bits are held.
- PC, SP and CCR update independently and may all change in the same cycle.
- While rst=1, every write, pc_op, sp_op and ccr_mask input is ignored.

## Timing
- Reset: on a rising edge with rst=1, all general registers, pc and ccr become 0, and sp becomes SP_RESET.
- Reset output values: pc=0, sp=SP_RESET, ccr=0. Each rd_data port shows 0; bypass is suppressed while rst=1.
- Reset mid-operation: a write or op presented in the same cycle as rst=1 is lost. The edge after rst falls uses normal operation.
- Write latency: the stored value is visible through the array one edge later. Through bypass it is visible in the same cycle (combinational).
- Special-register latency: pc, sp and ccr outputs change on the edge following the op. There is no bypass on these outputs.
- No handshake: every input is sampled on every rising edge.
- Combinational path: read address → rd_data. There is no combinational path from pc_op, sp_op or ccr inputs to the outputs.

## Test plan
- Reset, then drop rst: pc=0, sp=2047, ccr=0. Reading r0..r7 on all ports gives 0.
- Set we0=1, wa0=3, wd0=16'hBEEF with rd_addr port 2 = 3: rd_data port 2 shows 16'hBEEF in the same cycle. After the edge, with we0=0, it still reads 16'hBEEF.
- Set we0=we1=1, wa0=wa1=5, wd0=16'h1111, wd1=16'h2222: bypass and the stored value both give 16'h2222.
- PC sequence:
  - pc_op=10 with pc_wdata=32'hFFFF_FFFF gives pc=FFFF_FFFF
  - then pc_op=01 gives pc=0
  - then pc_op=11 with pc_wdata=32'h40 gives pc=32'h3F
- SP sequence from reset:
  - push, push gives sp=2043
  - then pop gives 2045
  - then load 1 followed by push gives 32'hFFFF_FFFF
- CCR and reset interaction:
  - ccr_mask=4'b0101, ccr_wdata=4'b1111 from ccr=0 gives ccr=4'b0101
  - asserting rst with we0=1, wa0=2 gives r2=0 and ccr=0 after the edge
